// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register 2-bit countdown of cycles until a destination is ready.
// Optional macro SB_BYPASS_EN: a source with one cycle left counts as ready (forwarded).
module reg_scoreboard #(
    parameter int unsigned LOAD_LAT = 3,
    parameter int unsigned ALU_LAT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       issue_vld0,
    input  logic       issue_vld1,
    input  logic [4:0] issue_dst0,
    input  logic [4:0] issue_dst1,
    input  logic       issue_wr0,
    input  logic       issue_wr1,
    input  logic       issue_ld0,
    input  logic       issue_ld1,
    input  logic [4:0] rs0,
    input  logic [4:0] rt0,
    input  logic [4:0] rs1,
    input  logic [4:0] rt1,
    output logic       ready0,
    output logic       ready1,
    output logic       idle
);

    localparam int unsigned NREG   = 32;
    localparam logic [1:0]  LD_CNT = 2'(LOAD_LAT);
    localparam logic [1:0]  AL_CNT = 2'(ALU_LAT);

    logic [NREG-1:0][1:0] r_cnt;
    logic [NREG-1:0][1:0] w_cnt_nxt;
    logic                 r_idle;
    logic                 w_all_zero;
    logic [1:0]           w_lat0;
    logic [1:0]           w_lat1;

    assign w_lat0 = issue_ld0 ? LD_CNT : AL_CNT;
    assign w_lat1 = issue_ld1 ? LD_CNT : AL_CNT;

    // Priority per register: flush, then slot 1 (younger), then slot 0, then countdown.
    always_comb begin
        w_all_zero = 1'b1;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] != 2'd0) ? r_cnt[i] - 2'd1 : 2'd0;
            if (issue_vld0 && issue_wr0 && (issue_dst0 == 5'(i)))
                w_cnt_nxt[i] = w_lat0;
            if (issue_vld1 && issue_wr1 && (issue_dst1 == 5'(i)))
                w_cnt_nxt[i] = w_lat1;
            if (flush)
                w_cnt_nxt[i] = '0;
            if (w_cnt_nxt[i] != 2'd0)
                w_all_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idle <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idle <= w_all_zero;
        end
    end

    function automatic logic src_ready(input logic [1:0] cnt);
`ifdef SB_BYPASS_EN
        return (cnt <= 2'd1);
`else
        return (cnt == 2'd0);
`endif
    endfunction

    assign ready0 = src_ready(r_cnt[rs0]) && src_ready(r_cnt[rt0]);
    assign ready1 = src_ready(r_cnt[rs1]) && src_ready(r_cnt[rt1]);
    assign idle   = r_idle;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter LOAD_LAT, default 3, meaning cycles until a load destination becomes ready (legal range 1..3).
REQ-002 The block SHALL have parameter ALU_LAT, default 1, meaning cycles until a non-load destination becomes ready (legal range 1..3).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous clear of all pending state.
REQ-006 The block SHALL have ports issue_vld0 and issue_vld1, input, 1 bit each: slot 0 / slot 1 issues this cycle; slot 0 is older in program order.
REQ-007 The block SHALL have ports issue_dst0 and issue_dst1, input, `NUM_REGISTERS_LOG2` (5) bits each: destination register of each issuing slot.
REQ-008 The block SHALL have ports issue_wr0 and issue_wr1, input, 1 bit each: the slot writes a register.
REQ-009 The block SHALL have ports issue_ld0 and issue_ld1, input, 1 bit each: the slot is a load (`MEM_OP_READ`).
REQ-010 The block SHALL have ports rs0, rt0, rs1, rt1, input, 5 bits each: source registers of the candidate pair.
REQ-011 The block SHALL have ports ready0 and ready1, output, 1 bit each: all sources of the candidate in that slot are ready.
REQ-012 The block SHALL have port idle, output, 1 bit: no register is pending.

Function
REQ-013 The block SHALL keep one 2-bit countdown counter per register (32 counters); a register is busy while its counter is nonzero.
REQ-014 On a rising edge with issue_vldN && issue_wrN, the block SHALL load counter[issue_dstN] with LOAD_LAT if issue_ldN, else ALU_LAT.
REQ-015 Every nonzero counter not loaded in a cycle SHALL decrement by 1 per cycle and saturate at 0; it SHALL never wrap.
REQ-016 When both slots write the same register in the same cycle, the block SHALL load the slot 1 value.
REQ-017 A load to a register whose counter is nonzero SHALL overwrite it, with no decrement in that cycle.
REQ-018 ready0 SHALL be combinational: 1 iff neither counter[rs0] nor counter[rt0] is busy per REQ-026/REQ-027; ready1 likewise from rs1/rt1.
REQ-019 The ready outputs SHALL NOT reflect same-cycle issues; intra-pair dependencies are resolved outside this block.
REQ-020 idle SHALL be registered, equal to 1 iff all counters are 0 after the current edge's update.
REQ-021 flush SHALL zero all counters on the edge, overriding same-cycle issue; idle SHALL be 1 after that edge.
REQ-022 Latency SHALL be as follows: an instruction issued at edge E with latency L makes its destination ready from edge E+L onward.

Reset
REQ-023 While reset is high, the block SHALL force all counters to 0, which drives ready0=1, ready1=1 and idle=1, asynchronously and independent of clk.
REQ-024 Reset asserted mid-countdown SHALL discard all pending state; after deassertion, counting SHALL resume only from new issues.
REQ-025 Reset SHALL have priority over flush and issue.

Configuration
REQ-026 With macro SB_BYPASS_EN defined, the block SHALL treat a source as ready when its counter is 0 or 1, because the forwarding path supplies the value.
REQ-027 Without SB_BYPASS_EN, the block SHALL treat a source as ready only when its counter is 0; idle and the counters SHALL behave identically in both builds.

Verification
REQ-028 The bench SHALL cover: reset, then query rs0=5 rt0=6 -> ready0=1, ready1=1, idle=1.
REQ-029 The bench SHALL cover: issue slot0 ld dst=5 (LOAD_LAT=3), hold rs1=5 -> ready1=0 for 3 cycles and 1 from the 3rd edge on (no bypass); with SB_BYPASS_EN, ready1=1 from the 2nd edge.
REQ-030 The bench SHALL cover: same-cycle slot0 ld dst=7 and slot1 alu dst=7 -> counter[7]=1, rs0=7 ready after 1 edge.
REQ-031 The bench SHALL cover: ld dst=3, then 1 cycle later alu dst=3 -> counter reloaded to 1, r3 ready 1 edge after the second issue.
REQ-032 The bench SHALL cover: ld dst=9 plus flush in the next cycle -> idle=1 and ready for r9 after the flush edge; flush in the same cycle as an issue -> nothing pending.
REQ-033 The bench SHALL cover: async reset pulsed between clock edges during a countdown -> ready=1 and idle=1 immediately, with no clock edge needed.
